crossbar_route_unit: RTL
========================

# crossbar_route_unit

Datapath stage directly downstream of the per-master-port round-robin arbiters in the stream crossbar. It takes the per-port grant (source id) and grant-valid produced by the arbiters and steers the granted slave stream's data/last to each master port. Every master port has a 2-entry skid buffer: outputs are registered, and `m_ready_i` never reaches `s_ready_o` combinationally. Payload, packet boundaries and ordering pass through unchanged; the source id travels with each beat.

## Interface
- `T_DATA_WIDTH`, default 8, payload width.
- `S_DATA_COUNT`, default 2, number of slave (input) streams.
- `M_DATA_COUNT`, default 3, number of master (output) ports.
- `T_ID___WIDTH`, localparam, `$clog2(S_DATA_COUNT)`.
- `T_DEST_WIDTH`, localparam, `$clog2(M_DATA_COUNT)`.

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_in`  in  1  reset, asynchronous and active-low.
- `s_data_i`  in  `[T_DATA_WIDTH-1:0]` x S  slave payload.
- `s_dest_i`  in  `[T_DEST_WIDTH-1:0]` x S  slave destination port.
- `s_last_i`  in  S  slave end-of-packet.
- `s_valid_i`  in  S  slave valid.
- `s_ready_o`  out  S  slave ready.
- `grant_i`  in  `[T_ID___WIDTH-1:0]` x M  granted slave id per master port (arbiter `grant_o`).
- `grant_valid_i`  in  M  grant is valid this cycle (arbiter `arbiter_ready_o`).
- `m_data_o`  out  `[T_DATA_WIDTH-1:0]` x M  master payload.
- `m_id_o`  out  `[T_ID___WIDTH-1:0]` x M  source slave id of the beat.
- `m_last_o`  out  M  master end-of-packet.
- `m_valid_o`  out  M  master valid.
- `m_ready_i`  in  M  master ready.

## Operation
- Route enable for slave i to port j: `grant_valid_i[j] && grant_i[j]==i && s_dest_i[i]==j`. At most one j matches per i, because dest is unique.
- `s_ready_o[i]` = OR over j of (route enable i to j AND `!full[j]`). It is combinational from grant/dest/buffer state only.
- Push to port j: `s_valid_i[i] && s_ready_o[i]` for the granted i. The stored beat is {data, last, id=i}.
- Per-port buffer: output register (OUT) plus skid register (SKID). States:
  - EMPTY: push goes to OUT, next state ONE.
  - ONE, with a pop (`m_valid_o && m_ready_i`) and a push: push goes to OUT, stay ONE.
  - ONE, pop only: next state EMPTY.
  - ONE, push only: push goes to SKID, next state TWO.
  - TWO, pop: SKID moves to OUT, next state ONE.
  - TWO, no pop: hold.
- `full[j]` is (state==TWO). Push is impossible in TWO.
- `m_valid_o[j]` = (state != EMPTY). `m_data_o`, `m_last_o` and `m_id_o` are driven from OUT.
- Grant changes are followed blindly. Packet atomicity is the arbiter's job; this block never reorders or drops beats.
- A slave whose dest port is ungranted, granted to another slave, or full sees `s_ready_o=0`.
- `s_dest_i` values `>= M_DATA_COUNT` match no port, so `s_ready_o` stays 0 (stall, no drop).
- Out-of-range `grant_i` (`>= S_DATA_COUNT`) matches no slave.

## Timing
- Reset (`rst_in`=0, async): all buffers EMPTY; `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `m_id_o`=0; `s_ready_o` then follows its combinational rule (0 unless grant valid).
- Reset mid-packet: buffered beats are discarded; outputs go to reset values immediately, no glitch-free requirement.
- Latency: a beat accepted at edge N is on `m_*` with `m_valid_o`=1 after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle/port with `m_ready_i` held high. Ports are independent; M transfers can occur per cycle.
- Master handshake: `m_valid_o` and its payload hold stable until `m_ready_i`=1 (AXI-Stream rule).
- Backpressure: after `m_ready_i` drops, at most 2 beats are stored. `s_ready_o` drops on the cycle after the second push.

## Test plan
- Single beat: S0 sends data 0xA5, dest 1, last=1, with grant_i[1]=0 and grant_valid=1. Required: next cycle m_valid_o[1]=1, m_data_o[1]=0xA5, m_id_o[1]=0, m_last_o[1]=1; ports 0 and 2 stay invalid.
- Streaming: 4-beat packet 0x01..0x04 from S1 to port 2, m_ready_i=1. Required: 4 consecutive output beats, last only on 0x04, s_ready_o[1] continuously 1.
- Backpressure: same packet with m_ready_i[2]=0 from the start. Required: 2 beats accepted, then s_ready_o[1]=0. After raising ready: output order 0x01, 0x02, 0x03, 0x04 with no loss or duplication.
- Concurrent: S0 to port 0 and S1 to port 2 at the same time. Required: both ports output in the same cycle with correct ids.
- No grant: S0 valid to port 1 with grant_valid_i[1]=0, or grant_i[1]=1. Required: s_ready_o[0]=0, m_valid_o[1]=0.
- Async reset: assert rst_in while port 2 holds 2 beats. Required: m_valid_o=0 immediately; after release, the next push outputs only new data.

Source files
------------

// File: rtl/crossbar_route_unit.sv
// Steers each master port's granted slave beat into a 2-entry skid buffer (OUT + SKID).
// Latency 1 cycle; m_ready_i never reaches s_ready_o combinationally, full buffers stall slaves.
module crossbar_route_unit #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 2,
  parameter int unsigned M_DATA_COUNT = 3,
  localparam int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_last_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  output logic [S_DATA_COUNT-1:0]                    s_ready_o,
  input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_i,
  input  logic [M_DATA_COUNT-1:0]                    grant_valid_i,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  m_id_o,
  output logic [M_DATA_COUNT-1:0]                    m_last_o,
  output logic [M_DATA_COUNT-1:0]                    m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic                    last;
    logic [T_ID___WIDTH-1:0] id;
  } beat_t;

  state_e state_q [M_DATA_COUNT];
  beat_t  out_q   [M_DATA_COUNT];
  beat_t  skid_q  [M_DATA_COUNT];

  logic [M_DATA_COUNT-1:0] full;
  logic [M_DATA_COUNT-1:0] pop;
  logic [M_DATA_COUNT-1:0] push;
  beat_t                   push_beat [M_DATA_COUNT];

  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      full[j]      = (state_q[j] == TWO);
      m_valid_o[j] = (state_q[j] != EMPTY);
      pop[j]       = m_valid_o[j] && m_ready_i[j];
      m_data_o[j]  = out_q[j].data;
      m_last_o[j]  = out_q[j].last;
      m_id_o[j]    = out_q[j].id;
    end
  end

  // Dest is unique per slave, so each slave matches at most one port; each port's grant picks one slave.
  always_comb begin
    s_ready_o = '0;
    push      = '0;
    for (int j = 0; j < M_DATA_COUNT; j++) push_beat[j] = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        if (grant_valid_i[j] && (grant_i[j] == T_ID___WIDTH'(i)) &&
            (s_dest_i[i] == T_DEST_WIDTH'(j)) && !full[j]) begin
          s_ready_o[i] = 1'b1;
          if (s_valid_i[i]) begin
            push[j]      = 1'b1;
            push_beat[j] = '{data: s_data_i[i], last: s_last_i[i], id: T_ID___WIDTH'(i)};
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        state_q[j] <= EMPTY;
        out_q[j]   <= '0;
        skid_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        case (state_q[j])
          EMPTY: begin
            if (push[j]) begin
              out_q[j]   <= push_beat[j];
              state_q[j] <= ONE;
            end
          end
          ONE: begin
            if (push[j] && pop[j]) begin
              out_q[j] <= push_beat[j];
            end else if (pop[j]) begin
              state_q[j] <= EMPTY;
            end else if (push[j]) begin
              skid_q[j]  <= push_beat[j];
              state_q[j] <= TWO;
            end
          end
          TWO: begin
            if (pop[j]) begin
              out_q[j]   <= skid_q[j];
              state_q[j] <= ONE;
            end
          end
          default: state_q[j] <= EMPTY;
        endcase
      end
    end
  end

endmodule
